gpio_in_conditioner: RTL and testbench

Input-side conditioning stage for the AHB GPIO peripheral.
- Takes raw asynchronous pad inputs, synchronises them into HCLK with a two-flop synchroniser and debounces each bit independently.
- Appends the parity bit that the GPIO block's parity checker expects, and drives the GPIO block's 17-bit GPIOIN bus directly.
- Emits per-bit one-cycle change pulses for future interrupt logic.

---
 rtl/gpio_in_conditioner.sv | 128 ++++++++++++
 tb/tb_gpio_in_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_conditioner.sv
// Purpose : synchronise, debounce and parity-extend raw GPIO pad inputs for the AHB GPIO block.
// Latency : capture edge k -> GPIOIN at k+1+DB_CYCLES (debounce built), k+2 (debounce not built).
// Backpressure: none; GPIOIN is a level bus valid every cycle and CHANGE pulses are not held.
//
// Optional feature macro: GPIO_IN_DEBOUNCE_EN
//   defined   -> per-bit debounce counters are built and DB_CYCLES applies.
//   undefined -> no counters; the stable level follows the synchroniser every edge.
//
// Ports:
//   HCLK        clock; every state update is on its rising edge
//   HRESET      synchronous active-high reset
//   PIN_IN      raw asynchronous pad levels, WIDTH bits
//   PARITYSEL   parity mode (0 = even, 1 = odd), quasi-static
//   GPIOIN      {parity, debounced level}; parity makes the total ones count match PARITYSEL
//   CHANGE      one-cycle pulse per bit on the edge where that bit's debounced level changes
//   CHANGE_ANY  OR of CHANGE

module gpio_in_conditioner #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] PIN_IN,
    input  logic             PARITYSEL,
    output logic [WIDTH:0]   GPIOIN,
    output logic [WIDTH-1:0] CHANGE,
    output logic             CHANGE_ANY
);

    // Legal DB_CYCLES is 1..255; the counter width below is sized from it
    // and a value outside that range has no meaningful debounce behaviour.
    if ((DB_CYCLES < 1) || (DB_CYCLES > 255)) begin : g_db_cycles_out_of_range
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser. sync1 is the metastability-exposed stage and
    // must not be used by anything except sync2.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= PIN_IN;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Stable level and change pulse, next-state computed below per build.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] st_q;
    logic [WIDTH-1:0] st_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;

`ifdef GPIO_IN_DEBOUNCE_EN
    // Counter holds the number of consecutive samples that disagreed with
    // st_q so far; it never exceeds DB_CYCLES-1, so there is no wrap.
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    always_comb begin
        st_d  = st_q;
        chg_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2[i] == st_q[i]) begin
                // Any agreeing sample discards a partial run, so a short
                // excursion never accumulates across bounces.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // This is the DB_CYCLES-th consecutive differing sample.
                st_d[i]  = sync2[i];
                cnt_d[i] = '0;
                chg_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // No filtering: the stable level is simply one more register stage
    // behind the synchroniser, and every difference is reported.
    always_comb begin
        st_d  = sync2;
        chg_d = sync2 ^ st_q;
    end
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st_q  <= '0;
            chg_q <= '0;
        end else begin
            st_q  <= st_d;
            chg_q <= chg_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Parity is combinational so a PARITYSEL change is visible in
    // the same cycle without waiting for an edge.
    // ------------------------------------------------------------------
    assign GPIOIN     = {(^st_q) ^ PARITYSEL, st_q};
    assign CHANGE     = chg_q;
    assign CHANGE_ANY = |chg_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Purpose : directed, table-driven bench for gpio_in_conditioner (WIDTH=16, DB_CYCLES=4).
// Latency : expectations are expressed relative to the capture edge of a stimulus change.
// Backpressure: not applicable; outputs are sampled 1 time unit after each rising edge.

module tb_gpio_in_conditioner;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT    = 5;  // capture edge -> stable update, DB_CYCLES=4
    localparam int DB_MIN = 4;  // shortest pulse that is accepted
`else
    localparam int LAT    = 2;
    localparam int DB_MIN = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pin;
    logic        psel;
    logic [16:0] gpio;
    logic [15:0] chg;
    logic        chg_any;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gpio_in_conditioner #(
        .WIDTH     (16),
        .DB_CYCLES (4)
    ) dut (
        .HCLK       (clk),
        .HRESET     (rst),
        .PIN_IN     (pin),
        .PARITYSEL  (psel),
        .GPIOIN     (gpio),
        .CHANGE     (chg),
        .CHANGE_ANY (chg_any)
    );

    typedef struct {
        logic [15:0] pin;
        logic        psel;
        logic [16:0] exp_prev;  // GPIOIN one edge before the update
        logic [16:0] exp_gpio;  // GPIOIN after the update
        logic [15:0] exp_chg;   // CHANGE on the update cycle
    } step_t;

    step_t steps [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock: drive inputs at the falling edge, check all outputs after the rising edge.
    task automatic cyc(input string name, input logic r, input logic [15:0] p, input logic ps,
                       input logic [16:0] eg, input logic [15:0] ec);
        @(negedge clk);
        rst  = r;
        pin  = p;
        psel = ps;
        @(posedge clk);
        #1;
        check({name, " gpio"}, 32'(gpio), 32'(eg));
        check({name, " change"}, 32'(chg), 32'(ec));
        check({name, " change_any"}, 32'(chg_any), 32'(|ec));
    endtask

    task automatic settle(input logic [15:0] p, input logic ps, input int n);
        @(negedge clk);
        rst  = 1'b0;
        pin  = p;
        psel = ps;
        repeat (n) @(posedge clk);
    endtask

    // Apply one table step and check the cycle before, of and after the update.
    task automatic run_step(input int idx);
        @(negedge clk);
        pin  = steps[idx].pin;
        psel = steps[idx].psel;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == LAT - 1) begin
                check($sformatf("step%0d gpio before", idx), 32'(gpio), 32'(steps[idx].exp_prev));
                check($sformatf("step%0d change before", idx), 32'(chg), 32'(0));
            end else if (c == LAT) begin
                check($sformatf("step%0d gpio", idx), 32'(gpio), 32'(steps[idx].exp_gpio));
                check($sformatf("step%0d change", idx), 32'(chg), 32'(steps[idx].exp_chg));
                check($sformatf("step%0d change_any", idx), 32'(chg_any), 32'(1));
            end else if (c == LAT + 1) begin
                check($sformatf("step%0d gpio after", idx), 32'(gpio), 32'(steps[idx].exp_gpio));
                check($sformatf("step%0d change after", idx), 32'(chg), 32'(0));
            end
        end
    endtask

    // Pulse of len cycles on PIN_IN[0] from an all-zero idle state.
    task automatic pulse(input int len);
        logic        acc;
        logic        hi;
        logic [15:0] p;
        acc = (len >= DB_MIN);
        for (int n = 0; n <= len + LAT + 1; n++) begin
            p  = (n < len) ? 16'h0001 : 16'h0000;
            hi = acc && (n >= LAT) && (n <= len + LAT - 1);
            cyc($sformatf("pulse%0d n%0d", len, n), 1'b0, p, 1'b0,
                hi ? 17'h10001 : 17'h00000,
                (acc && (n == LAT || n == len + LAT)) ? 16'h0001 : 16'h0000);
        end
    endtask

    initial begin
        logic [0:10] pat;
        logic [0:10] lvl;
        logic [0:10] cmask;

        steps[0] = '{16'h0008, 1'b0, 17'h00000, 17'h10008, 16'h0008};
        steps[1] = '{16'h0009, 1'b0, 17'h10008, 17'h00009, 16'h0001};
        steps[2] = '{16'hA5A5, 1'b1, 17'h10009, 17'h1A5A5, 16'hA5AC};
        steps[3] = '{16'h5A5B, 1'b1, 17'h1A5A5, 17'h05A5B, 16'hFFFE};
        steps[4] = '{16'hFFFF, 1'b0, 17'h15A5B, 17'h0FFFF, 16'hA5A4};
        steps[5] = '{16'h0000, 1'b0, 17'h0FFFF, 17'h00000, 16'hFFFF};
        steps[6] = '{16'h8001, 1'b1, 17'h10000, 17'h18001, 16'h8001};
        steps[7] = '{16'h8000, 1'b0, 17'h08001, 17'h18000, 16'h0001};

        rst  = 1'b1;
        pin  = 16'hFFFF;
        psel = 1'b1;

        // Reset with all pins high and odd parity, then re-acceptance after release.
        cyc("reset0", 1'b1, 16'hFFFF, 1'b1, 17'h10000, 16'h0000);
        cyc("reset1", 1'b1, 16'hFFFF, 1'b1, 17'h10000, 16'h0000);
        for (int n = 0; n <= LAT + 1; n++) begin
            cyc($sformatf("release n%0d", n), 1'b0, 16'hFFFF, 1'b1,
                (n >= LAT) ? 17'h1FFFF : 17'h10000,
                (n == LAT) ? 16'hFFFF : 16'h0000);
        end

        // Reset again with pins low and even parity to start the step table.
        cyc("reset2", 1'b1, 16'h0000, 1'b0, 17'h00000, 16'h0000);
        cyc("idle", 1'b0, 16'h0000, 1'b0, 17'h00000, 16'h0000);

        for (int i = 0; i < 8; i++) run_step(i);

        // PARITYSEL must reach GPIOIN[16] without a clock edge.
        @(negedge clk);
        psel = 1'b1;
        #1;
        check("parity comb odd", 32'(gpio), 32'(17'h08000));
        @(negedge clk);
        psel = 1'b0;
        #1;
        check("parity comb even", 32'(gpio), 32'(17'h18000));

        // Glitch rejection and pulse acceptance on bit 0.
        settle(16'h0000, 1'b0, LAT + 2);
        pulse(1);
        pulse(3);
        pulse(4);
        pulse(6);

        // Bounce on bit 5: 1,1,1,0 then a steady run of 1s.
        pat = 11'b11101111111;
`ifdef GPIO_IN_DEBOUNCE_EN
        lvl   = 11'b00000000011;
        cmask = 11'b00000000010;
`else
        lvl   = 11'b00111011111;
        cmask = 11'b00100110000;
`endif
        for (int n = 0; n <= 10; n++) begin
            cyc($sformatf("bounce n%0d", n), 1'b0, pat[n] ? 16'h0020 : 16'h0000, 1'b0,
                lvl[n] ? 17'h10020 : 17'h00000, cmask[n] ? 16'h0020 : 16'h0000);
        end

        // Step to 00F0 interrupted by a two-cycle reset two cycles after capture.
        settle(16'h0000, 1'b0, LAT + 2);
        cyc("pre midreset", 1'b0, 16'h0000, 1'b0, 17'h00000, 16'h0000);
        for (int n = 0; n <= 4 + LAT + 1; n++) begin
            cyc($sformatf("midreset n%0d", n), (n == 2 || n == 3), 16'h00F0, 1'b0,
                (n >= 4 + LAT) ? 17'h000F0 : 17'h00000,
                (n == 4 + LAT) ? 16'h00F0 : 16'h0000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
